// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: ALU opcodes and sequencer state encoding.
package alu_mul_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110
  } alu_ctl_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ADD,
    SEQ_SHIFT,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Start/result handshake plus the ALU drive/return path of the multiply sequencer.
interface alu_mul_seq_if #(parameter int WIDTH = 16);
  logic             MUL_START;
  logic [WIDTH-1:0] MUL_A;
  logic [WIDTH-1:0] MUL_B;
  logic             MUL_BUSY;
  logic             MUL_DONE;
  logic [WIDTH-1:0] MUL_P;
  logic             MUL_OVF;
  logic [WIDTH-1:0] SEQ_DA;
  logic [WIDTH-1:0] SEQ_DB;
  logic [2:0]       SEQ_CTL;
  logic [3:0]       SEQ_SHIFT;
  logic [WIDTH-1:0] SEQ_DC;

  modport master (
    output MUL_START, MUL_A, MUL_B, SEQ_DC,
    input  MUL_BUSY, MUL_DONE, MUL_P, MUL_OVF, SEQ_DA, SEQ_DB, SEQ_CTL, SEQ_SHIFT
  );

  modport slave (
    input  MUL_START, MUL_A, MUL_B, SEQ_DC,
    output MUL_BUSY, MUL_DONE, MUL_P, MUL_OVF, SEQ_DA, SEQ_DB, SEQ_CTL, SEQ_SHIFT
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the execute-stage ALU for its adds and shifts.
// Produces the low WIDTH bits of an unsigned product and flags overflow.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);

  localparam int CNT_W = 5;

  seq_state_e       state, state_n;
  logic [WIDTH-1:0] acc, mcand, mplier, mplier_sh;
  logic [CNT_W-1:0] cnt;
  logic             ovf, last_iter;

  assign mplier_sh = mplier >> 1;
  assign last_iter = (cnt == CNT_W'(WIDTH-1)) || (EARLY_EXIT && (mplier_sh == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.SEQ_DA    = '0;
    bus.SEQ_DB    = '0;
    bus.SEQ_CTL   = ALU_ADD;
    bus.SEQ_SHIFT = 4'd0;
    case (state)
      SEQ_IDLE:  if (bus.MUL_START) state_n = SEQ_ADD;
      SEQ_ADD: begin
        bus.SEQ_DA = acc;
        bus.SEQ_DB = mcand;
        state_n    = SEQ_SHIFT;
      end
      SEQ_SHIFT: begin
        bus.SEQ_DA    = mcand;
        bus.SEQ_CTL   = ALU_SLL;
        bus.SEQ_SHIFT = 4'd1;
        state_n       = last_iter ? SEQ_DONE : SEQ_ADD;
      end
      SEQ_DONE:  state_n = SEQ_IDLE;
      default:   state_n = SEQ_IDLE;
    endcase
  end

  // Overflow has two sources: a carry out of an accumulate, or a multiplicand
  // bit shifted off the top while higher multiplier bits still need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: if (bus.MUL_START) begin
          mcand  <= bus.MUL_A;
          mplier <= bus.MUL_B;
          acc    <= '0;
          cnt    <= '0;
          ovf    <= 1'b0;
        end
        SEQ_ADD: if (mplier[0]) begin
          acc <= bus.SEQ_DC;
          if (bus.SEQ_DC < acc) ovf <= 1'b1;
        end
        SEQ_SHIFT: begin
          mcand  <= bus.SEQ_DC;
          mplier <= mplier_sh;
          cnt    <= cnt + CNT_W'(1);
          if (mcand[WIDTH-1] && (mplier_sh != '0)) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.MUL_BUSY = (state != SEQ_IDLE);
  assign bus.MUL_DONE = (state == SEQ_DONE);
  assign bus.MUL_P    = acc;
  assign bus.MUL_OVF  = ovf;

endmodule
